// File: rtl/sdr_port_arbiter.sv
// rtl/sdr_port_arbiter.sv - round-robin N-client arbiter with priority lock onto one SDRAM channel
module sdr_port_arbiter #(
  parameter int N_CLIENTS   = 4,
  parameter int AW          = 24,
  parameter int DW          = 16,
  parameter int PRIO_CLIENT = 0,
  parameter int TIMEOUT     = 1023
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic                         prio_lock,
  input  logic [N_CLIENTS-1:0]         cli_req,
  input  logic [N_CLIENTS*AW-1:0]      cli_addr,
  input  logic [N_CLIENTS*DW-1:0]      cli_din,
  input  logic [N_CLIENTS*2-1:0]       cli_be,
  output logic [N_CLIENTS-1:0]         cli_rdy,
  output logic [DW-1:0]                cli_dout,
  output logic [AW-1:0]                mem_addr,
  output logic [DW-1:0]                mem_din,
  output logic [1:0]                   mem_be,
  output logic                         mem_rnw,
  output logic                         mem_req,
  input  logic                         mem_rdy,
  input  logic [DW-1:0]                mem_dout,
  output logic [$clog2(N_CLIENTS)-1:0] grant_idx,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int GW      = $clog2(N_CLIENTS);
  localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TLAST    = TLAST_I[CW-1:0];
  localparam logic [GW-1:0] PRIO_IDX = PRIO_CLIENT[GW-1:0];

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           r_state;
  logic [GW-1:0]        r_rr_ptr;
  logic [GW-1:0]        r_grant;
  logic [CW-1:0]        r_cnt;
  logic [N_CLIENTS-1:0] r_rdy;
  logic [DW-1:0]        r_dout;
  logic [AW-1:0]        r_mem_addr;
  logic [DW-1:0]        r_mem_din;
  logic [1:0]           r_mem_be;
  logic                 r_mem_rnw;
  logic                 r_mem_req;
  logic                 r_terr;

  logic                 w_found;
  logic [GW-1:0]        w_pick;
  logic [AW-1:0]        w_addr;
  logic [DW-1:0]        w_din;
  logic [1:0]           w_be;

  // Index arithmetic modulo N_CLIENTS, which need not be a power of two.
  function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_CLIENTS) s = s - N_CLIENTS;
    return s[GW-1:0];
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    if (prio_lock) begin
      w_found = cli_req[PRIO_CLIENT];
      w_pick  = PRIO_IDX;
    end else begin
      for (int k = 0; k < N_CLIENTS; k++) begin
        if (!w_found && cli_req[wrap_add(r_rr_ptr, k)]) begin
          w_found = 1'b1;
          w_pick  = wrap_add(r_rr_ptr, k);
        end
      end
    end
    w_addr = cli_addr[int'(w_pick)*AW +: AW];
    w_din  = cli_din[int'(w_pick)*DW +: DW];
    w_be   = cli_be[int'(w_pick)*2 +: 2];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_cnt      <= '0;
      r_rdy      <= '0;
      r_dout     <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_be   <= '0;
      r_mem_rnw  <= 1'b1;
      r_mem_req  <= 1'b0;
      r_terr     <= 1'b0;
    end else begin
      r_rdy <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_mem_addr <= w_addr;
            r_mem_din  <= w_din;
            r_mem_be   <= w_be;
            r_mem_rnw  <= ~|w_be;
            r_mem_req  <= 1'b1;
            r_grant    <= w_pick;
            r_rr_ptr   <= wrap_add(w_pick, 1);
            r_cnt      <= '0;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          // A completion on the expiry cycle takes precedence over the watchdog.
          if (mem_rdy) begin
            r_mem_req       <= 1'b0;
            r_rdy[r_grant]  <= 1'b1;
            r_cnt           <= '0;
            r_state         <= DONE;
            if (r_mem_rnw) r_dout <= mem_dout;
          end else if (TIMEOUT > 0 && r_cnt == TLAST) begin
            r_mem_req       <= 1'b0;
            r_rdy[r_grant]  <= 1'b1;
            r_terr          <= 1'b1;
            r_cnt           <= '0;
            r_state         <= DONE;
          end else if (TIMEOUT > 0) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cli_rdy     = r_rdy;
  assign cli_dout    = r_dout;
  assign mem_addr    = r_mem_addr;
  assign mem_din     = r_mem_din;
  assign mem_be      = r_mem_be;
  assign mem_rnw     = r_mem_rnw;
  assign mem_req     = r_mem_req;
  assign grant_idx   = r_grant;
  assign busy        = (r_state != IDLE);
  assign timeout_err = r_terr;

endmodule
